// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES byte layout helpers and GF(2^8) inverse-round functions
package aes_pkg;

    // Columns per block; block[127:96] is column 0 and [127:120] is row 0.
    localparam int NB = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } dec_state_e;

    function automatic logic [7:0] get_byte(input logic [127:0] blk, input int c, input int r);
        return blk[127 - 8*(NB*c + r) -: 8];
    endfunction

    function automatic logic [31:0] get_col(input logic [127:0] blk, input int c);
        return blk[127 - 32*c -: 32];
    endfunction

    // xtime: multiply by 2 in GF(2^8) with the AES polynomial.
    function automatic logic [7:0] gm2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul_09(input logic [7:0] b);
        logic [7:0] b8;
        b8 = gm2(gm2(gm2(b)));
        return b8 ^ b;
    endfunction

    function automatic logic [7:0] gmul_0b(input logic [7:0] b);
        logic [7:0] b2;
        logic [7:0] b8;
        b2 = gm2(b);
        b8 = gm2(gm2(b2));
        return b8 ^ b2 ^ b;
    endfunction

    function automatic logic [7:0] gmul_0d(input logic [7:0] b);
        logic [7:0] b4;
        logic [7:0] b8;
        b4 = gm2(gm2(b));
        b8 = gm2(b4);
        return b8 ^ b4 ^ b;
    endfunction

    function automatic logic [7:0] gmul_0e(input logic [7:0] b);
        logic [7:0] b2;
        logic [7:0] b4;
        logic [7:0] b8;
        b2 = gm2(b);
        b4 = gm2(b2);
        b8 = gm2(b4);
        return b8 ^ b4 ^ b2;
    endfunction

    // Row r rotates right by r: output column c takes input column (c - r) mod 4.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] blk);
        logic [127:0] res;
        res = '0;
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < 4; r++) begin
                res[127 - 8*(NB*c + r) -: 8] = get_byte(blk, (c - r + NB) % NB, r);
            end
        end
        return res;
    endfunction

    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        logic [7:0] b3;
        b0 = col[31:24];
        b1 = col[23:16];
        b2 = col[15:8];
        b3 = col[7:0];
        return {gmul_0e(b0) ^ gmul_0b(b1) ^ gmul_0d(b2) ^ gmul_09(b3),
                gmul_09(b0) ^ gmul_0e(b1) ^ gmul_0b(b2) ^ gmul_0d(b3),
                gmul_0d(b0) ^ gmul_09(b1) ^ gmul_0e(b2) ^ gmul_0b(b3),
                gmul_0b(b0) ^ gmul_0d(b1) ^ gmul_09(b2) ^ gmul_0e(b3)};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] blk);
        logic [127:0] res;
        res = '0;
        for (int c = 0; c < NB; c++) begin
            res[127 - 32*c -: 32] = inv_mix_column(get_col(blk, c));
        end
        return res;
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// rtl/aes_inv_sbox.sv - combinational 256-entry AES inverse S-box
module aes_inv_sbox (
    input  logic [7:0] byte_i,
    output logic [7:0] byte_o
);

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    // Pure table lookup.
    always_comb begin
        byte_o = INV_SBOX[byte_i];
    end

endmodule

// File: rtl/aes_decryption_core.sv
// rtl/aes_decryption_core.sv - iterative AES inverse cipher, one inverse round per clock
module aes_decryption_core
    import aes_pkg::*;
#(
    parameter int NR     = 10,
    parameter int KIDX_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    output logic              i_ready,
    input  logic [127:0]      i_block,
    output logic [KIDX_W-1:0] o_key_idx,
    input  logic [127:0]      i_round_key,
    output logic              o_valid,
    input  logic              o_ready,
    output logic [127:0]      o_block
);

    localparam logic [KIDX_W-1:0] KIDX_NR   = KIDX_W'(NR);
    localparam logic [KIDX_W-1:0] KIDX_LAST = KIDX_W'(NR - 1);
    localparam logic [KIDX_W-1:0] KIDX_ONE  = KIDX_W'(1);

    dec_state_e        fsm_q, fsm_d;
    logic [KIDX_W-1:0] rnd_q, rnd_d;
    logic [127:0]      blk_q, blk_d;
    logic [127:0]      oblk_q, oblk_d;
    logic              ovalid_q, ovalid_d;

    logic [127:0]      shifted;
    logic [127:0]      subbed;
    logic [127:0]      keyed;
    logic [127:0]      mixed;

    assign shifted = inv_shift_rows(blk_q);

    for (genvar k = 0; k < 16; k++) begin : g_sbox
        aes_inv_sbox u_inv_sbox (
            .byte_i (shifted[127 - 8*k -: 8]),
            .byte_o (subbed[127 - 8*k -: 8])
        );
    end

    assign keyed = subbed ^ i_round_key;
    assign mixed = inv_mix_columns(keyed);

    assign o_valid = ovalid_q;
    assign o_block = oblk_q;

    // Next-state, round counter, datapath selects and handshake outputs.
    always_comb begin
        fsm_d     = fsm_q;
        rnd_d     = rnd_q;
        blk_d     = blk_q;
        oblk_d    = oblk_q;
        ovalid_d  = ovalid_q;
        i_ready   = 1'b0;
        o_key_idx = KIDX_NR;
        case (fsm_q)
            ST_IDLE: begin
                i_ready = 1'b1;
                if (i_valid) begin
                    blk_d = i_block ^ i_round_key;
                    rnd_d = KIDX_LAST;
                    fsm_d = ST_RUN;
                end
            end
            ST_RUN: begin
                o_key_idx = rnd_q;
                if (rnd_q != '0) begin
                    blk_d = mixed;
                    rnd_d = rnd_q - KIDX_ONE;
                end else begin
                    // Final round skips InvMixColumns.
                    oblk_d   = keyed;
                    ovalid_d = 1'b1;
                    fsm_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                if (o_ready) begin
                    ovalid_d = 1'b0;
                    fsm_d    = ST_IDLE;
                end
            end
            default: begin
                fsm_d    = ST_IDLE;
                ovalid_d = 1'b0;
            end
        endcase
    end

    // State, counter and output registers; reset drops any in-flight block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q    <= ST_IDLE;
            rnd_q    <= '0;
            blk_q    <= '0;
            oblk_q   <= '0;
            ovalid_q <= 1'b0;
        end else begin
            fsm_q    <= fsm_d;
            rnd_q    <= rnd_d;
            blk_q    <= blk_d;
            oblk_q   <= oblk_d;
            ovalid_q <= ovalid_d;
        end
    end

endmodule

// File: tb/tb_aes_decryption_core.sv
// tb/tb_aes_decryption_core.sv - self-checking bench for aes_decryption_core (NR=10 and NR=14)
module tb_aes_decryption_core;
    import aes_pkg::*;

    localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C3_CT = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         iv_a, ir_a, ov_a, ordy_a;
    logic [127:0] ib_a, ob_a, key_a;
    logic [3:0]   kidx_a;
    logic         iv_b, ir_b, ov_b, ordy_b;
    logic [127:0] ib_b, ob_b, key_b;
    logic [3:0]   kidx_b;

    logic [127:0] rk_a [0:15];
    logic [127:0] rk_b [0:15];
    assign key_a = rk_a[kidx_a];
    assign key_b = rk_b[kidx_b];

    aes_decryption_core #(.NR(10), .KIDX_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .i_valid(iv_a), .i_ready(ir_a), .i_block(ib_a),
        .o_key_idx(kidx_a), .i_round_key(key_a), .o_valid(ov_a), .o_ready(ordy_a), .o_block(ob_a)
    );

    aes_decryption_core #(.NR(14), .KIDX_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .i_valid(iv_b), .i_ready(ir_b), .i_block(ib_b),
        .o_key_idx(kidx_b), .i_round_key(key_b), .o_valid(ov_b), .o_ready(ordy_b), .o_block(ob_b)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [127:0] q_a [$];
    logic [127:0] q_b [$];
    logic [7:0]   sbox_t [0:255];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired at cycle %0d", name, cyc);
    endtask

    // ---------------- reference model: forward AES built from GF arithmetic ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                      ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    function automatic logic [127:0] mix128(input logic [127:0] blk);
        logic [127:0] res;
        logic [7:0] b0, b1, b2, b3;
        for (int c = 0; c < 4; c++) begin
            {b0, b1, b2, b3} = blk[127 - 32*c -: 32];
            res[127 - 32*c -: 32] = {gmul(b0, 2) ^ gmul(b1, 3) ^ b2 ^ b3,
                                     b0 ^ gmul(b1, 2) ^ gmul(b2, 3) ^ b3,
                                     b0 ^ b1 ^ gmul(b2, 2) ^ gmul(b3, 3),
                                     gmul(b0, 3) ^ b1 ^ b2 ^ gmul(b3, 2)};
        end
        return res;
    endfunction

    // Key schedule; d selects which store (0: NR=10 / Nk=4, 1: NR=14 / Nk=8).
    task automatic expand(input int d, input logic [255:0] key);
        logic [31:0] w [0:59];
        logic [31:0] tmp;
        logic [7:0]  rc;
        int nk, nr;
        nk = (d == 0) ? 4 : 8;
        nr = nk + 6;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        rc = 8'h01;
        for (int i = nk; i < 4*(nr+1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                tmp = subw(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        for (int r = 0; r <= nr; r++) begin
            if (d == 0) rk_a[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else        rk_b[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
    endtask

    task automatic encrypt(input int d, input logic [127:0] pt, output logic [127:0] ct);
        logic [127:0] s, t;
        int nr;
        nr = (d == 0) ? 10 : 14;
        s = pt ^ ((d == 0) ? rk_a[0] : rk_b[0]);
        for (int r = 1; r <= nr; r++) begin
            for (int k = 0; k < 16; k++) t[127 - 8*k -: 8] = sbox_t[s[127 - 8*k -: 8]];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++)
                    s[127 - 8*(4*c + rr) -: 8] = t[127 - 8*(4*((c + rr) % 4) + rr) -: 8];
            if (r < nr) s = mix128(s);
            s = s ^ ((d == 0) ? rk_a[r] : rk_b[r]);
        end
        ct = s;
    endtask

    // ---------------- cycle-level compare against the transaction model ----------------
    bit busy  [2];
    bit acc_p [2];
    bit hs_p  [2];
    int acc_e [2];

    always @(negedge clk) begin
        logic         iv, ir, ov, ordy;
        logic [127:0] ob;
        logic [3:0]   kidx;
        int           nr, age;
        bit           exp_ov, exp_ir, qempty;
        for (int d = 0; d < 2; d++) begin
            iv   = (d == 0) ? iv_a   : iv_b;
            ir   = (d == 0) ? ir_a   : ir_b;
            ov   = (d == 0) ? ov_a   : ov_b;
            ordy = (d == 0) ? ordy_a : ordy_b;
            ob   = (d == 0) ? ob_a   : ob_b;
            kidx = (d == 0) ? kidx_a : kidx_b;
            nr   = (d == 0) ? 10 : 14;
            if (!rst_n) begin
                chk("reset_o_valid", 128'(ov), 128'(0));
                chk("reset_i_ready", 128'(ir), 128'(1));
                chk("reset_o_block", ob, 128'h0);
                busy[d]  = 1'b0;
                acc_p[d] = 1'b0;
                hs_p[d]  = 1'b0;
                if (d == 0) q_a.delete(); else q_b.delete();
            end else begin
                if (acc_p[d]) begin busy[d] = 1'b1; acc_e[d] = cyc; end
                if (hs_p[d]) busy[d] = 1'b0;
                acc_p[d] = 1'b0;
                hs_p[d]  = 1'b0;
                age    = cyc - acc_e[d];
                exp_ov = busy[d] && (age >= nr);
                exp_ir = !busy[d];
                chk("o_valid", 128'(ov), 128'(exp_ov));
                chk("i_ready", 128'(ir), 128'(exp_ir));
                if (!busy[d]) chk("o_key_idx_idle", 128'(kidx), 128'(nr));
                else if (age < nr) chk("o_key_idx_run", 128'(kidx), 128'(nr - 1 - age));
                if (exp_ov) begin
                    qempty = (d == 0) ? (q_a.size() == 0) : (q_b.size() == 0);
                    if (qempty) chk("o_block_unexpected", ob, 128'hx);
                    else chk("o_block", ob, (d == 0) ? q_a[0] : q_b[0]);
                    if (ordy) begin
                        hs_p[d] = 1'b1;
                        if (!qempty) begin
                            if (d == 0) void'(q_a.pop_front()); else void'(q_b.pop_front());
                        end
                    end
                end
                acc_p[d] = iv && exp_ir;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input int d, input logic [127:0] ct, input logic [127:0] pt);
        bit ok;
        if (d == 0) q_a.push_back(pt); else q_b.push_back(pt);
        @(posedge clk); #1;
        if (d == 0) begin iv_a = 1'b1; ib_a = ct; end else begin iv_b = 1'b1; ib_b = ct; end
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            ok = (d == 0) ? ir_a : ir_b;
        end
        if (!ok) timeout("send_accept");
        @(posedge clk); #1;
        if (d == 0) begin iv_a = 1'b0; ib_a = {4{$urandom()}}; end
        else        begin iv_b = 1'b0; ib_b = {4{$urandom()}}; end
    endtask

    task automatic wait_idle(input int d);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge clk);
            ok = (d == 0) ? (ir_a && q_a.size() == 0) : (ir_b && q_b.size() == 0);
        end
        if (!ok) timeout("wait_idle");
    endtask

    task automatic wait_kidx(input logic [3:0] v);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            ok = !ir_a && (kidx_a == v);
        end
        if (!ok) timeout("wait_key_idx");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] ct, pt, x, held;
        bit ok;
        rst_n = 1'b0;
        iv_a = 1'b0; ib_a = '0; ordy_a = 1'b1;
        iv_b = 1'b0; ib_b = '0; ordy_b = 1'b1;
        for (int i = 0; i < 16; i++) begin rk_a[i] = '0; rk_b[i] = '0; end

        build_sbox();
        expand(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0});
        expand(1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);

        // Literal pins on the model itself.
        chk("model_sbox_00", 128'(sbox_t[8'h00]), 128'h63);
        chk("model_sbox_53", 128'(sbox_t[8'h53]), 128'hed);
        chk("model_rk10_c1", rk_a[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        encrypt(0, PT, ct);
        chk("model_enc_c1", ct, C1_CT);
        encrypt(1, PT, ct);
        chk("model_enc_c3", ct, C3_CT);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Test 1 / Test 2: FIPS vectors on both widths.
        send(0, C1_CT, PT);
        wait_idle(0);
        send(1, C3_CT, PT);
        wait_idle(1);

        // Random plaintexts through the forward model.
        for (int n = 0; n < 4; n++) begin
            pt = {$urandom(), $urandom(), $urandom(), $urandom()};
            encrypt(0, pt, ct);
            send(0, ct, pt);
            wait_idle(0);
            encrypt(1, pt, ct);
            send(1, ct, pt);
            wait_idle(1);
        end

        // Test 3: InvMixColumns package function.
        chk("inv_mix_column_literal", 128'(inv_mix_column(32'h8e4da1bc)), 128'hdb135345);
        for (int n = 0; n < 1000; n++) begin
            x = {$urandom(), $urandom(), $urandom(), $urandom()};
            chk("inv_mix_roundtrip", inv_mix_columns(mix128(x)), x);
        end

        // Test 4: backpressure.
        ordy_a = 1'b0;
        send(0, C1_CT, PT);
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = ov_a;
        end
        if (!ok) timeout("bp_o_valid");
        held = ob_a;
        chk("bp_first_block", held, PT);
        repeat (5) begin
            @(negedge clk);
            chk("bp_stable", ob_a, held);
            chk("bp_valid", 128'(ov_a), 128'(1));
            chk("bp_busy", 128'(ir_a), 128'(0));
        end
        @(posedge clk); #1 ordy_a = 1'b1;
        @(posedge clk); #1 ordy_a = 1'b0;
        @(negedge clk);
        chk("bp_release_ready", 128'(ir_a), 128'(1));
        chk("bp_release_valid", 128'(ov_a), 128'(0));
        ordy_a = 1'b1;
        wait_idle(0);

        // Test 5: i_valid with junk during round 4 is ignored.
        send(0, C1_CT, PT);
        wait_kidx(4'd4);
        #1;
        iv_a = 1'b1;
        ib_a = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
        @(posedge clk); #1 iv_a = 1'b0;
        wait_idle(0);
        repeat (3) @(negedge clk);
        chk("busy_no_extra_output", 128'(ov_a), 128'(0));

        // Test 6: reset mid-run, then a clean decrypt.
        send(0, C1_CT, PT);
        wait_kidx(4'd5);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_o_valid_now", 128'(ov_a), 128'(0));
        chk("midrst_i_ready_now", 128'(ir_a), 128'(1));
        repeat (3) @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        send(0, C1_CT, PT);
        wait_idle(0);
        send(1, C3_CT, PT);
        wait_idle(1);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
